mmss_timer_ctrl: RTL
====================

# mmss_timer_ctrl

Parametrised mm:ss countdown controller for the egg-timer design, replacing the fixed set/start/count control block. It lets the user set minutes and seconds with up/down buttons, counts down once per 1 Hz tick, and supports pause/resume and clear. On expiry it either raises a timed alarm or auto-reloads the preset. It sits between the debounced button inputs and tick generator on one side, and the 7-segment display driver and buzzer on the other. All logic runs in the single `clk` domain.

## Interface
- `MIN_TENS_MAX`, default 5: maximum minutes-tens digit; the settable range is 00:00 to (MIN_TENS_MAX*10+9):59.
- `ALARM_TICKS`, default 10: number of 1 Hz ticks the alarm stays asserted before it self-clears; legal range 1–255.
- `AUTO_RELOAD`, default 0: expiry mode. 0 = alarm mode; 1 = reload the preset and keep running.

- `clk`  in  1  system clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `tick_1hz`  in  1  one-`clk`-wide strobe, once per second.
- `min_up`, `min_down`, `sec_up`, `sec_down`  in  1 each  debounced one-cycle button pulses.
- `start_pause`  in  1  one-cycle pulse; starts, pauses or resumes the countdown.
- `clear`  in  1  one-cycle pulse; aborts and returns to SET.
- `min_tens`, `min_ones`, `sec_tens`, `sec_ones`  out  4 each  BCD digits of the current time.
- `state_o`  out  2  current state: SET=0, RUN=1, PAUSE=2, ALARM=3.
- `running`  out  1  high while in RUN.
- `alarm`  out  1  high while in ALARM.
- `done`  out  1  one-cycle pulse on each expiry, in both modes.

## Operation
- Reset values:
  - state = SET.
  - All four digits = 0 and preset = 00:00.
  - `running`, `alarm`, `done` = 0; alarm tick counter = 0.
- Input priority within a cycle: `clear` > `start_pause` > `tick_1hz` effects > up/down buttons.
- SET state:
  - `sec_up` wraps 59→00; `sec_down` wraps 00→59. Seconds never carry into or borrow from minutes.
  - `min_up` and `min_down` wrap between 00 and MIN_TENS_MAX*10+9.
  - An up and a down pulse for the same field in the same cycle produce no change.
  - `tick_1hz` is ignored.
  - `start_pause` with a nonzero time: capture the time into preset and go to RUN.
  - `start_pause` with 00:00: stay in SET and do nothing.
- RUN state:
  - Each tick decrements the time by one second with BCD borrow: sec_ones 0→9, sec_tens 0→5, min_ones 0→9, min_tens decremented.
  - If the tick takes the time from 00:01 to 00:00: pulse `done`. In alarm mode go to ALARM with the display at 00:00. In reload mode load the preset and stay in RUN.
  - `start_pause` goes to PAUSE. A tick in the same cycle is still applied.
  - Up/down buttons are ignored.
- PAUSE state:
  - The time is frozen and ticks are ignored.
  - `start_pause` returns to RUN.
- `clear` from RUN, PAUSE or ALARM: go to SET with time = preset. `clear` in SET sets the time to 00:00.
- ALARM state:
  - `alarm` = 1. The counter increments on each tick.
  - When the counter reaches ALARM_TICKS, go to SET with time = preset and clear the counter.
  - `start_pause` or `clear` acknowledges immediately: go to SET with time = preset.
- Digits never leave their legal ranges: ones 0–9, sec_tens 0–5, min_tens 0–MIN_TENS_MAX.

## Timing
- All outputs are registered and reflect an input event on the `clk` edge after it is sampled; latency is 1 cycle.
- `done` is high for exactly the cycle after the expiring tick, coincident with the first cycle of ALARM or of the reloaded value.
- The tick phase is free-running. The first decrement after start occurs on the next `tick_1hz`, 1–CLK_HZ cycles later.
- Asserting `reset` mid-count forces all outputs to their reset values immediately, independent of `clk`.
- Inputs are assumed synchronous to `clk`. A button held high for N cycles counts as N presses, so the upstream debouncer supplies single-cycle pulses.

## Structure
- Package `egg_timer_pkg` holds:
  - the state encoding constants (SET/RUN/PAUSE/ALARM);
  - the BCD limits 9 and 5;
  - the alarm counter width (8).
- Sub-module `bcd_digit`, instantiated four times:
  - one BCD digit register with a parametrised max value;
  - `inc`/`dec`/`load` controls;
  - `carry_out`/`borrow_out` outputs;
  - asynchronous reset to 0.
- The top level contains the FSM, the preset register, the alarm counter, and the borrow-chain wiring, where only the seconds pair chains into the minutes pair in RUN.

## Test plan
- Reset; `sec_up`×3, `min_up`×1, `start_pause`; 3 ticks → display 01:00, `running`=1.
- Set 00:02, start, 2 ticks (alarm mode, ALARM_TICKS=3) → `done` pulses once, `alarm`=1; after 3 more ticks → SET with display 00:02.
- Same sequence with AUTO_RELOAD=1 → after 2 ticks `done` pulses, display 00:02, `running` stays 1.
- `sec_down` from 00 → 59. `min_up` from 59 with MIN_TENS_MAX=5 → 00. Simultaneous `sec_up`+`sec_down` → unchanged.
- Run from 10:00; `start_pause` together with a tick → 09:59, state PAUSE; 5 ticks → still 09:59; `clear` → 10:00 in SET.
- `start_pause` at 00:00 → stays in SET. `reset` asserted mid-RUN → all outputs 0 asynchronously, state SET.

Source files
------------

// File: rtl/egg_timer_pkg.sv
// ---------------------------------------------------------------
// egg_timer_pkg : shared state encoding and limits for the timer
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package egg_timer_pkg;

  typedef enum logic [1:0] {
    ST_SET   = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ALARM = 2'd3
  } state_e;

  localparam int BCD_ONES_MAX = 9;
  localparam int BCD_TENS_MAX = 5;
  localparam int ALARM_CNT_W  = 8;

endpackage

`default_nettype wire

// File: rtl/bcd_digit.sv
// ---------------------------------------------------------------
// bcd_digit : one wrapping BCD digit with inc/dec/load and chain flags
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module bcd_digit #(
  parameter int MAX = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       dec,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] q,
  output logic       carry_out,
  output logic       borrow_out
);

  localparam logic [3:0] MAX_V = 4'(MAX);

  logic [3:0] q_d, q_q;
  logic       up, dn;

  // Opposing pulses in the same cycle cancel out.
  assign up         = inc & ~dec;
  assign dn         = dec & ~inc;
  assign carry_out  = up & (q_q == MAX_V);
  assign borrow_out = dn & (q_q == 4'd0);
  assign q          = q_q;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = load_val;
    end else if (up) begin
      q_d = carry_out ? 4'd0 : q_q + 4'd1;
    end else if (dn) begin
      q_d = borrow_out ? MAX_V : q_q - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q_q <= 4'd0;
    else       q_q <= q_d;
  end

endmodule

`default_nettype wire

// File: rtl/mmss_timer_ctrl.sv
// ---------------------------------------------------------------
// mmss_timer_ctrl : mm:ss countdown FSM with preset, alarm and reload
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module mmss_timer_ctrl
  import egg_timer_pkg::*;
#(
  parameter int MIN_TENS_MAX = 5,
  parameter int ALARM_TICKS  = 10,
  parameter int AUTO_RELOAD  = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       min_up,
  input  logic       min_down,
  input  logic       sec_up,
  input  logic       sec_down,
  input  logic       start_pause,
  input  logic       clear,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [1:0] state_o,
  output logic       running,
  output logic       alarm,
  output logic       done
);

  state_e                 state_q, state_d;
  logic [15:0]            preset_q, preset_d;
  logic [ALARM_CNT_W-1:0] alarm_cnt_q, alarm_cnt_d;
  logic                   done_q, done_d, running_q, running_d, alarm_q, alarm_d;

  logic        load;
  logic [15:0] load_val;
  logic [15:0] time_now;
  logic        set_btn, run_tick, expire;
  logic        so_inc, so_dec, st_inc, st_dec, mo_inc, mo_dec, mt_inc, mt_dec;
  logic        so_carry, so_borrow, st_carry, st_borrow;
  logic        mo_carry, mo_borrow, mt_carry, mt_borrow;
  logic        unused_flags;

  assign time_now = {min_tens, min_ones, sec_tens, sec_ones};
  assign set_btn  = (state_q == ST_SET) & ~clear & ~start_pause;
  assign run_tick = (state_q == ST_RUN) & tick_1hz;
  assign expire   = run_tick & (time_now == 16'h0001);

  // Seconds and minutes chain separately when setting; only a running tick
  // lets the seconds borrow ripple into the minutes.
  assign so_inc = set_btn & sec_up;
  assign so_dec = (set_btn & sec_down) | run_tick;
  assign st_inc = so_carry;
  assign st_dec = so_borrow;
  assign mo_inc = set_btn & min_up;
  assign mo_dec = (set_btn & min_down) | (run_tick & st_borrow);
  assign mt_inc = mo_carry;
  assign mt_dec = mo_borrow;

  assign unused_flags = ^{st_carry, mt_carry, mt_borrow};

  bcd_digit #(.MAX(BCD_ONES_MAX)) u_sec_ones (
    .clk(clk), .reset(reset), .inc(so_inc), .dec(so_dec), .load(load),
    .load_val(load_val[3:0]), .q(sec_ones), .carry_out(so_carry), .borrow_out(so_borrow)
  );
  bcd_digit #(.MAX(BCD_TENS_MAX)) u_sec_tens (
    .clk(clk), .reset(reset), .inc(st_inc), .dec(st_dec), .load(load),
    .load_val(load_val[7:4]), .q(sec_tens), .carry_out(st_carry), .borrow_out(st_borrow)
  );
  bcd_digit #(.MAX(BCD_ONES_MAX)) u_min_ones (
    .clk(clk), .reset(reset), .inc(mo_inc), .dec(mo_dec), .load(load),
    .load_val(load_val[11:8]), .q(min_ones), .carry_out(mo_carry), .borrow_out(mo_borrow)
  );
  bcd_digit #(.MAX(MIN_TENS_MAX)) u_min_tens (
    .clk(clk), .reset(reset), .inc(mt_inc), .dec(mt_dec), .load(load),
    .load_val(load_val[15:12]), .q(min_tens), .carry_out(mt_carry), .borrow_out(mt_borrow)
  );

  always_comb begin
    state_d     = state_q;
    preset_d    = preset_q;
    alarm_cnt_d = alarm_cnt_q;
    done_d      = 1'b0;
    load        = 1'b0;
    load_val    = preset_q;
    case (state_q)
      ST_SET: begin
        if (clear) begin
          load     = 1'b1;
          load_val = 16'h0000;
        end else if (start_pause && (time_now != 16'h0000)) begin
          preset_d = time_now;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (clear) begin
          load    = 1'b1;
          state_d = ST_SET;
        end else if (expire) begin
          done_d = 1'b1;
          if (AUTO_RELOAD != 0) begin
            load    = 1'b1;
            state_d = start_pause ? ST_PAUSE : ST_RUN;
          end else begin
            state_d = ST_ALARM;
          end
        end else if (start_pause) begin
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (clear) begin
          load    = 1'b1;
          state_d = ST_SET;
        end else if (start_pause) begin
          state_d = ST_RUN;
        end
      end
      ST_ALARM: begin
        if (clear || start_pause) begin
          load        = 1'b1;
          state_d     = ST_SET;
          alarm_cnt_d = '0;
        end else if (tick_1hz) begin
          if (alarm_cnt_q == ALARM_CNT_W'(ALARM_TICKS - 1)) begin
            load        = 1'b1;
            state_d     = ST_SET;
            alarm_cnt_d = '0;
          end else begin
            alarm_cnt_d = alarm_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_SET;
    endcase
    running_d = (state_d == ST_RUN);
    alarm_d   = (state_d == ST_ALARM);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_SET;
      preset_q    <= 16'h0000;
      alarm_cnt_q <= '0;
      done_q      <= 1'b0;
      running_q   <= 1'b0;
      alarm_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      preset_q    <= preset_d;
      alarm_cnt_q <= alarm_cnt_d;
      done_q      <= done_d;
      running_q   <= running_d;
      alarm_q     <= alarm_d;
    end
  end

  assign state_o = state_q;
  assign running = running_q;
  assign alarm   = alarm_q;
  assign done    = done_q;

endmodule

`default_nettype wire
